// File: rtl/charram_dram_sequencer_pkg.sv
// charram_dram_sequencer_pkg: shared widths, FSM encoding and address-mux helper
// for the 4416 character-RAM DRAM sequencer.
package charram_dram_sequencer_pkg;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 6;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 4;
    localparam int COL_LSB = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ROW, S_COL, S_XFER, S_DONE, S_PRE, S_RFSH
    } state_t;

    // Column phase puts addr[13:8] on DRAM pins [6:1]; pins 7 and 0 stay low.
    function automatic logic [ROW_W-1:0] col_addr(input logic [ADDR_W-1:0] a);
        return ROW_W'(a[ADDR_W-1 -: COL_W]) << COL_LSB;
    endfunction
endpackage

// File: rtl/charram_dram_sequencer_refresh_timer.sv
// charram_dram_sequencer_refresh_timer: refresh interval timer, RAS-only row counter
// and pending/overdue flags; only built with CHARRAM_REFRESH_EN.
module charram_dram_sequencer_refresh_timer
    import charram_dram_sequencer_pkg::*;
#(
    parameter int INTERVAL = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             ack,
    output logic             pend,
    output logic             over,
    output logic [ROW_W-1:0] row
);
    logic [15:0]      cnt_q, cnt_d;
    logic             pend_q, pend_d, over_q, over_d, tick;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        tick   = cen && cnt_q == 16'(INTERVAL - 1);
        cnt_d  = tick ? 16'd0 : cen ? cnt_q + 16'd1 : cnt_q;
        pend_d = ack ? 1'b0 : pend_q | tick;
        // A second expiry while still pending marks the refresh as overdue.
        over_d = ack ? 1'b0 : over_q | (tick & pend_q);
        row_d  = ack ? row_q + 1'b1 : row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            over_q <= 1'b0;
            row_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            over_q <= over_d;
            row_q  <= row_d;
        end
    end

    assign pend = pend_q;
    assign over = over_q;
    assign row  = row_q;
endmodule

// File: rtl/charram_dram_sequencer.sv
// charram_dram_sequencer: 4416 DRAM access sequencer/arbiter for video and CPU.
// Define CHARRAM_REFRESH_EN to add RAS-only refresh.
module charram_dram_sequencer
    import charram_dram_sequencer_pkg::*;
#(
    parameter int CPU_STARVE_LIMIT = 2,
    parameter int REFRESH_INTERVAL = 60
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CEN,
    input  logic              i_VID_REQ,
    input  logic [ADDR_W-1:0] i_VID_ADDR,
    output logic [DATA_W-1:0] o_VID_DATA,
    output logic              o_VID_VALID,
    input  logic              i_CPU_REQ,
    input  logic              i_CPU_WE,
    input  logic [ADDR_W-1:0] i_CPU_ADDR,
    input  logic [DATA_W-1:0] i_CPU_DIN,
    output logic [DATA_W-1:0] o_CPU_DOUT,
    output logic              o_CPU_ACK,
    output logic [ROW_W-1:0]  o_DRAM_ADDR,
    output logic [DATA_W-1:0] o_DRAM_DIN,
    input  logic [DATA_W-1:0] i_DRAM_DOUT,
    output logic              o_RAS_n,
    output logic              o_CAS_n,
    output logic              o_WR_n,
    output logic              o_RD_n
);
    state_t            state_q, state_d;
    logic [7:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, vid_data_q, vid_data_d, cpu_dout_q, cpu_dout_d;
    logic              we_q, we_d, own_q, own_d, vid_valid_q, vid_valid_d, cpu_ack_q, cpu_ack_d;
    logic              cpu_win, rfsh_ack, rfsh_pend, rfsh_over;
    logic [ROW_W-1:0]  rfsh_row;

`ifdef CHARRAM_REFRESH_EN
    charram_dram_sequencer_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh (
        .clk  (i_MCLK),
        .rst  (i_RST),
        .cen  (i_CEN),
        .ack  (rfsh_ack),
        .pend (rfsh_pend),
        .over (rfsh_over),
        .row  (rfsh_row)
    );
`else
    logic unused_rfsh;
    assign unused_rfsh = rfsh_ack ^ (^32'(REFRESH_INTERVAL));
    assign rfsh_pend   = 1'b0;
    assign rfsh_over   = 1'b0;
    assign rfsh_row    = '0;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        we_d        = we_q;
        din_d       = din_q;
        own_d       = own_q;
        vid_data_d  = vid_data_q;
        cpu_dout_d  = cpu_dout_q;
        vid_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        rfsh_ack    = 1'b0;
        cpu_win     = i_CPU_REQ && (!i_VID_REQ || starve_q == 8'(CPU_STARVE_LIMIT));
        if (i_CEN) begin
            case (state_q)
                S_IDLE: begin
                    if (rfsh_over) begin
                        state_d = S_RFSH;
                    end else if (cpu_win) begin
                        state_d  = S_ROW;
                        own_d    = 1'b1;
                        addr_d   = i_CPU_ADDR;
                        we_d     = i_CPU_WE;
                        din_d    = i_CPU_DIN;
                        starve_d = '0;
                    end else if (i_VID_REQ) begin
                        state_d  = S_ROW;
                        own_d    = 1'b0;
                        addr_d   = i_VID_ADDR;
                        we_d     = 1'b0;
                        starve_d = i_CPU_REQ ? starve_q + 8'd1 : starve_q;
                    end else if (rfsh_pend) begin
                        state_d = S_RFSH;
                    end
                end
                S_ROW:  state_d = S_COL;
                S_COL:  state_d = S_XFER;
                S_XFER: state_d = S_DONE;
                S_DONE: begin
                    state_d     = S_PRE;
                    cpu_ack_d   = own_q;
                    vid_valid_d = !own_q;
                    vid_data_d  = own_q ? vid_data_q : i_DRAM_DOUT;
                    cpu_dout_d  = own_q && !we_q ? i_DRAM_DOUT : cpu_dout_q;
                end
                S_RFSH: begin
                    state_d  = S_PRE;
                    rfsh_ack = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            own_q       <= 1'b0;
            vid_data_q  <= '0;
            cpu_dout_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            din_q       <= din_d;
            own_q       <= own_d;
            vid_data_q  <= vid_data_d;
            cpu_dout_q  <= cpu_dout_d;
            vid_valid_q <= vid_valid_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    // Strobes decode straight from the async-reset state so reset releases them at once.
    assign o_RAS_n     = !(state_q inside {S_ROW, S_COL, S_XFER, S_RFSH});
    assign o_CAS_n     = !(state_q inside {S_COL, S_XFER});
    assign o_RD_n      = !(state_q == S_XFER && !we_q);
    assign o_WR_n      = !(state_q == S_XFER && we_q);
    assign o_DRAM_ADDR = state_q == S_ROW ? addr_q[ROW_W-1:0]
                       : state_q inside {S_COL, S_XFER} ? col_addr(addr_q)
                       : state_q == S_RFSH ? rfsh_row : '0;
    assign o_DRAM_DIN  = din_q;
    assign o_VID_DATA  = vid_data_q;
    assign o_VID_VALID = vid_valid_q;
    assign o_CPU_DOUT  = cpu_dout_q;
    assign o_CPU_ACK   = cpu_ack_q;
endmodule

// File: tb/tb_charram_dram_sequencer.sv
// tb_charram_dram_sequencer: directed self-checking bench with a small 4416 DRAM model.
module tb_charram_dram_sequencer;
`ifdef CHARRAM_REFRESH_EN
    localparam int RI = 8;
`else
    localparam int RI = 60;
`endif
    logic        clk = 1'b0, rst = 1'b1, cen = 1'b1;
    logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [13:0] vid_addr = '0, cpu_addr = '0;
    logic [3:0]  cpu_din = '0, dram_dout = '0;
    logic [3:0]  vid_data, cpu_dout, dram_din;
    logic        vid_valid, cpu_ack, ras_n, cas_n, wr_n, rd_n;
    logic [7:0]  dram_addr, row_lat = '0, cur_row = '0;
    logic [3:0]  mem [0:16383];
    logic        ras_prev = 1'b1, cas_seen = 1'b0;
    logic [7:0]  acc_rows[$], rf_rows[$];
    logic [7:0]  exp_rows [0:5] = '{8'h00, 8'h00, 8'h34, 8'h00, 8'h00, 8'h34};
    int          n_chk = 0, n_fail = 0, t, a, v;
    logic [3:0]  d;

    always #5 clk = ~clk;

    charram_dram_sequencer #(.CPU_STARVE_LIMIT(2), .REFRESH_INTERVAL(RI)) dut (
        .i_MCLK(clk), .i_RST(rst), .i_CEN(cen),
        .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_DATA(vid_data), .o_VID_VALID(vid_valid),
        .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
        .o_CPU_DOUT(cpu_dout), .o_CPU_ACK(cpu_ack),
        .o_DRAM_ADDR(dram_addr), .o_DRAM_DIN(dram_din), .i_DRAM_DOUT(dram_dout),
        .o_RAS_n(ras_n), .o_CAS_n(cas_n), .o_WR_n(wr_n), .o_RD_n(rd_n)
    );

    always @(posedge clk) begin
        if (!ras_n && cas_n) row_lat <= dram_addr;
        if (!wr_n) mem[{dram_addr[6:1], row_lat}] <= dram_din;
        if (!rd_n) dram_dout <= mem[{dram_addr[6:1], row_lat}];
    end

    // Each RAS cycle is logged at its end: with a CAS phase it is an access, without one a refresh.
    always @(posedge clk) begin
        ras_prev <= ras_n;
        if (ras_prev && !ras_n) begin
            cur_row  <= dram_addr;
            cas_seen <= 1'b0;
        end else if (!ras_n && !cas_n) cas_seen <= 1'b1;
        if (!ras_prev && ras_n) begin
            if (cas_seen) acc_rows.push_back(cur_row);
            else rf_rows.push_back(cur_row);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_xfer(input logic we, input logic [13:0] ad, input logic [3:0] dn, output int ticks);
        cpu_we = we; cpu_addr = ad; cpu_din = dn; cpu_req = 1'b1; ticks = 0;
        while (!cpu_ack && ticks < 40) begin step(); ticks++; end
        cpu_req = 1'b0;
        step();
        check("cpu_ack_width", cpu_ack, 0);
    endtask

    task automatic vid_read(input logic [13:0] ad, output int ticks, output logic [3:0] dd);
        vid_addr = ad; vid_req = 1'b1;
        step();
        vid_req = 1'b0; ticks = 1;
        while (!vid_valid && ticks < 40) begin step(); ticks++; end
        dd = vid_data;
        step();
        check("vid_valid_width", vid_valid, 0);
    endtask

    task automatic count_pulses(input int n, output int acks, output int valids);
        acks = 0; valids = 0;
        for (int i = 0; i < n; i++) begin
            step();
            acks += int'(cpu_ack);
            valids += int'(vid_valid);
        end
    endtask

    initial begin
        step(); step();
        check("rst_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
        check("rst_addr", dram_addr, 0);
        check("rst_din", dram_din, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_valid", vid_valid, 0);
        check("rst_ack", cpu_ack, 0);
        rst = 1'b0;
`ifdef CHARRAM_REFRESH_EN
        t = 0;
        while (rf_rows.size() < 3 && t < 200) begin step(); t++; end
        check("rf_row0", rf_rows[0], 8'd0);
        check("rf_row1", rf_rows[1], 8'd1);
        check("rf_row2", rf_rows[2], 8'd2);
        while (rf_rows.size() < 257 && t < 4000) begin step(); t++; end
        check("rf_row255", rf_rows[255], 8'd255);
        check("rf_row_wrap", rf_rows[256], 8'd0);
        rst = 1'b1;
        step();
        acc_rows.delete(); rf_rows.delete();
        rst = 1'b0; vid_addr = 14'h3FFF; vid_req = 1'b1; t = 0;
        while (rf_rows.size() == 0 && t < 100) begin step(); t++; end
        check("rf_forced_ticks", t, 21);
        check("rf_forced_after_vid", acc_rows.size(), 3);
        check("rf_forced_row", rf_rows[0], 8'd0);
        vid_req = 1'b0;
`else
        mem[14'h0000] = 4'h3;
        mem[14'h3FFF] = 4'hA;
        cpu_we = 1'b1; cpu_addr = 14'h2A5F; cpu_din = 4'hC; cpu_req = 1'b1;
        step();
        check("wr_row_addr", dram_addr, 8'h5F);
        check("wr_row_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'b0111);
        step();
        check("wr_col_addr", dram_addr, 8'h54);
        check("wr_col_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'b0011);
        step();
        check("wr_xfer_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'b0001);
        check("wr_din", dram_din, 4'hC);
        step();
        check("wr_done_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
        check("wr_done_din", dram_din, 4'hC);
        step();
        check("wr_ack_tick5", cpu_ack, 1);
        cpu_req = 1'b0;
        step();
        check("wr_ack_width", cpu_ack, 0);

        cen = 1'b0; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (4) step();
        check("cen_hold_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
        cen = 1'b1;
        cpu_xfer(1'b0, 14'h2A5F, 4'h0, t);
        check("rd_latency", t, 5);
        check("rd_dout", cpu_dout, 4'hC);

        cpu_we = 1'b0; cpu_addr = 14'h2A5F; cpu_req = 1'b1;
        step(); step(); step();
        check("xfer_rd_strobe", rd_n, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
        check("rst_mid_dout", cpu_dout, 0);
        check("rst_mid_addr", dram_addr, 0);
        step();
        rst = 1'b0; cpu_req = 1'b0;
        count_pulses(10, a, v);
        check("rst_mid_no_ack", a, 0);

        vid_read(14'h0000, t, d);
        check("vid0_latency", t, 5);
        check("vid0_data", d, 4'h3);
        vid_read(14'h3FFF, t, d);
        check("vid1_latency", t, 5);
        check("vid1_data", d, 4'hA);

        acc_rows.delete();
        vid_addr = 14'h0000; vid_req = 1'b1;
        step();
        vid_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h1234; cpu_req = 1'b1;
        step(); step();
        cpu_req = 1'b0;
        count_pulses(10, a, v);
        check("withdraw_no_ack", a, 0);
        check("withdraw_accesses", acc_rows.size(), 1);
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        count_pulses(10, a, v);
        check("drop_after_grant_ack", a, 1);

        acc_rows.delete();
        vid_addr = 14'h0000; cpu_addr = 14'h1234; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1; t = 0;
        while (acc_rows.size() < 6 && t < 120) begin step(); t++; end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("arb_grants", acc_rows.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("arb_grant%0d", i), acc_rows[i], exp_rows[i]);
        repeat (10) step();
        check("no_refresh", rf_rows.size(), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
